// File: rtl/reg_window_ctrl.sv
// Frame-pointer controller: sequences CALL/RTN window moves and keeps a stack of call offsets.
// Define FP_STACK_CHECK_EN for overflow/underflow faults; otherwise FP wraps and the stack is circular.
module reg_window_ctrl #(
  parameter int STACK_DEPTH = 4,
  parameter int FP_MAX      = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_call_req,
  input  logic       i_rtn_req,
  input  logic [2:0] i_offset,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_fault,
  output logic [3:0] o_fp,
  output logic [3:0] o_new_fp,
  output logic       o_fp_move,
  output logic       o_fp_push_up,
  output logic [2:0] o_move_off,
  output logic [2:0] o_depth
);

  localparam int         PTR_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [2:0] C_DEPTH_MAX = 3'(STACK_DEPTH);
  localparam logic [4:0] C_FP_MAX    = 5'(FP_MAX);
`ifdef FP_STACK_CHECK_EN
  localparam bit         C_CHECK     = 1'b1;
`else
  localparam bit         C_CHECK     = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DONE, S_FAULT} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [3:0]             r_fp;
  logic [3:0]             r_target;
  logic [2:0]             r_off;
  logic                   r_up;
  logic [2:0]             r_depth;
  logic [PTR_W-1:0]       r_top;
  logic [STACK_DEPTH-1:0][2:0] w_stack;

  logic [4:0]       w_sum;
  logic             w_full;
  logic             w_empty;
  logic [PTR_W-1:0] w_top_m1;
  logic [2:0]       w_pop_off;
  logic             w_call_ok;
  logic             w_rtn_ok;
  logic             w_push;
  logic             w_pop;

  assign w_sum     = {1'b0, r_fp} + {2'b00, i_offset};
  assign w_full    = (r_depth == C_DEPTH_MAX);
  assign w_empty   = (r_depth == 3'd0);
  assign w_top_m1  = r_top - PTR_W'(1);
  // An empty pop (only reachable without checking) returns offset 0, leaving FP unchanged.
  assign w_pop_off = w_empty ? 3'd0 : w_stack[w_top_m1];
  assign w_call_ok = !C_CHECK || ((w_sum <= C_FP_MAX) && !w_full);
  assign w_rtn_ok  = !C_CHECK || !w_empty;

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_call_req) begin
          if (w_call_ok) begin
            w_state_next = S_MOVE;
            w_push       = 1'b1;
          end else begin
            w_state_next = S_FAULT;
          end
        end else if (i_rtn_req) begin
          if (w_rtn_ok) begin
            w_state_next = S_MOVE;
            w_pop        = 1'b1;
          end else begin
            w_state_next = S_FAULT;
          end
        end
      end
      S_MOVE:  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      S_FAULT: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_fp     <= 4'd0;
      r_target <= 4'd0;
      r_off    <= 3'd0;
      r_up     <= 1'b0;
      r_depth  <= 3'd0;
      r_top    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_push) begin
        r_target <= w_sum[3:0];
        r_off    <= i_offset;
        r_up     <= 1'b1;
        r_top    <= r_top + PTR_W'(1);
        // A full push overwrites the oldest entry; depth saturates.
        if (!w_full) begin
          r_depth <= r_depth + 3'd1;
        end
      end
      if (w_pop) begin
        r_target <= r_fp - {1'b0, w_pop_off};
        r_off    <= w_pop_off;
        r_up     <= 1'b0;
        if (!w_empty) begin
          r_top   <= w_top_m1;
          r_depth <= r_depth - 3'd1;
        end
      end
      if (r_state == S_MOVE) begin
        r_fp <= r_target;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
      logic [2:0] r_entry;
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_entry <= 3'd0;
        end else if (w_push && (r_top == PTR_W'(gi))) begin
          r_entry <= i_offset;
        end
      end
      assign w_stack[gi] = r_entry;
    end
  endgenerate

  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
`ifdef FP_STACK_CHECK_EN
  assign o_fault      = (r_state == S_FAULT);
`else
  assign o_fault      = 1'b0;
`endif
  assign o_fp         = r_fp;
  assign o_fp_move    = (r_state == S_MOVE);
  assign o_new_fp     = o_fp_move ? r_target : r_fp;
  assign o_fp_push_up = o_fp_move & r_up;
  assign o_move_off   = o_fp_move ? r_off : 3'd0;
  assign o_depth      = r_depth;

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Scoreboard bench for reg_window_ctrl: a stack/FP model queues expected moves, a monitor checks them.
module tb_reg_window_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_call_req;
  logic       i_rtn_req;
  logic [2:0] i_offset;
  logic       o_busy, o_done, o_fault, o_fp_move, o_fp_push_up;
  logic [3:0] o_fp, o_new_fp;
  logic [2:0] o_move_off, o_depth;

`ifdef FP_STACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  reg_window_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_call_req(i_call_req), .i_rtn_req(i_rtn_req),
    .i_offset(i_offset), .o_busy(o_busy), .o_done(o_done), .o_fault(o_fault),
    .o_fp(o_fp), .o_new_fp(o_new_fp), .o_fp_move(o_fp_move), .o_fp_push_up(o_fp_push_up),
    .o_move_off(o_move_off), .o_depth(o_depth)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit fault;
    bit up;
    int new_fp;
    int off;
    int depth;
  } exp_t;

  exp_t sb[$];
  int   m_fp;
  int   m_stk[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: FP as an integer, stack as a queue (back = top, front = oldest).
  task automatic model_req(input bit c, input bit r, input int off);
    exp_t e;
    int   k;
    e = '{fault: 1'b0, up: 1'b0, new_fp: 0, off: 0, depth: 0};
    if (c) begin
      if (CHK && ((m_fp + off > 8) || (m_stk.size() >= 4))) begin
        e.fault = 1'b1;
      end else begin
        m_stk.push_back(off);
        if (m_stk.size() > 4) void'(m_stk.pop_front());
        m_fp  = (m_fp + off) % 16;
        e.up  = 1'b1;
        e.off = off;
      end
    end else begin
      if (m_stk.size() == 0 && CHK) begin
        e.fault = 1'b1;
      end else begin
        k     = (m_stk.size() == 0) ? 0 : m_stk.pop_back();
        m_fp  = (m_fp - k + 16) % 16;
        e.off = k;
      end
    end
    e.new_fp = m_fp;
    e.depth  = m_stk.size();
    sb.push_back(e);
  endtask

  task automatic issue(input bit c, input bit r, input int off);
    int n = 0;
    while (o_busy && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("idle_timeout", int'(o_busy), 0);
    if (c || r) model_req(c, r, off);
    $display("req call=%0d rtn=%0d off=%0d -> model fp=%0d depth=%0d", c, r, off, m_fp, m_stk.size());
    i_call_req = c;
    i_rtn_req  = r;
    i_offset   = 3'(off);
    @(negedge i_clk);
    // Noise while busy must be ignored by the DUT.
    i_call_req = 1'($urandom);
    i_rtn_req  = 1'($urandom);
    i_offset   = 3'($urandom);
    @(negedge i_clk);
    i_call_req = 1'b0;
    i_rtn_req  = 1'b0;
    i_offset   = 3'd0;
  endtask

  task automatic do_reset();
    i_call_req = 1'b0;
    i_rtn_req  = 1'b0;
    i_reset    = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    m_fp    = 0;
    m_stk.delete();
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    exp_t cur;
    bit   exp_done;
    exp_done = 1'b0;
    cur      = '{fault: 1'b0, up: 1'b0, new_fp: 0, off: 0, depth: 0};
    forever begin
      @(posedge i_clk);
      #1;
      if (i_reset) begin
        sb.delete();
        exp_done = 1'b0;
      end else begin
        if (exp_done) begin
          chk("done_pulse", int'(o_done), 1);
          chk("done_fp", int'(o_fp), cur.new_fp);
          chk("done_depth", int'(o_depth), cur.depth);
          if (sb.size() > 0) void'(sb.pop_front());
          exp_done = 1'b0;
        end else begin
          chk("unexpected_done", int'(o_done), 0);
        end
        if (o_fp_move) begin
          if (sb.size() == 0) begin
            chk("unexpected_move", int'(o_fp_move), 0);
          end else begin
            cur = sb[0];
            chk("move_kind", 0, int'(cur.fault));
            chk("move_new_fp", int'(o_new_fp), cur.new_fp);
            chk("move_push_up", int'(o_fp_push_up), int'(cur.up));
            chk("move_off", int'(o_move_off), cur.off);
            chk("move_depth", int'(o_depth), cur.depth);
            chk("move_busy", int'(o_busy), 1);
            exp_done = 1'b1;
          end
        end else begin
          chk("idle_new_fp", int'(o_new_fp), int'(o_fp));
          chk("idle_move_off", int'(o_move_off) + int'(o_fp_push_up), 0);
        end
        if (o_fault) begin
          if (sb.size() == 0) begin
            chk("unexpected_fault", int'(o_fault), 0);
          end else begin
            chk("fault_kind", 1, int'(sb[0].fault));
            chk("fault_fp", int'(o_fp), sb[0].new_fp);
            chk("fault_depth", int'(o_depth), sb[0].depth);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int kind;
    int off;
    i_reset    = 1'b1;
    i_call_req = 1'b0;
    i_rtn_req  = 1'b0;
    i_offset   = 3'd0;
    m_fp       = 0;
    repeat (3) @(negedge i_clk);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_fault", int'(o_fault), 0);
    chk("rst_fp", int'(o_fp), 0);
    chk("rst_new_fp", int'(o_new_fp), 0);
    chk("rst_fp_move", int'(o_fp_move), 0);
    chk("rst_push_up", int'(o_fp_push_up), 0);
    chk("rst_move_off", int'(o_move_off), 0);
    chk("rst_depth", int'(o_depth), 0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Directed: CALL 3, CALL 2, RTN, RTN, RTN at empty, both-high at depth 1.
    issue(1, 0, 3);
    issue(1, 0, 2);
    issue(0, 1, 0);
    issue(0, 1, 0);
    issue(0, 1, 0);
    issue(1, 0, 1);
    issue(1, 1, 2);
    issue(0, 1, 0);
    issue(0, 1, 0);
    // FP=5 then CALL 4 exceeds FP_MAX when checking is enabled.
    issue(1, 0, 5);
    issue(1, 0, 4);
    // Stack overflow / circular overwrite, then drain past empty.
    do_reset();
    for (int i = 0; i < 5; i++) issue(1, 0, i % 3);
    for (int i = 0; i < 5; i++) issue(0, 1, 0);

    // Reset during MOVE abandons the move.
    do_reset();
    model_req(1, 0, 2);
    i_call_req = 1'b1;
    i_offset   = 3'd2;
    @(negedge i_clk);
    chk("rstmove_fp_move", int'(o_fp_move), 1);
    i_call_req = 1'b0;
    i_reset    = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    m_fp    = 0;
    m_stk.delete();
    chk("rstmove_fp", int'(o_fp), 0);
    chk("rstmove_depth", int'(o_depth), 0);
    chk("rstmove_busy", int'(o_busy), 0);
    chk("rstmove_done", int'(o_done), 0);
    repeat (3) @(negedge i_clk);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      kind = int'($urandom_range(0, 99));
      off  = $urandom_range(0, 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 7));
      if (kind < 55)      issue(1, 0, off);
      else if (kind < 95) issue(0, 1, off);
      else                issue(1, 1, off);
    end

    repeat (6) @(negedge i_clk);
    chk("sb_empty", sb.size(), 0);
    chk("final_fp", int'(o_fp), m_fp);
    chk("final_depth", int'(o_depth), m_stk.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_window_ctrl.md
# reg_window_ctrl

Frame-pointer controller for the 16-entry banked register file, which exposes an 8-register window at base FP. It sequences CALL and RTN window moves:
- accepts a request from the decoder;
- computes the new frame pointer;
- drives the register file's FP move controls for exactly one cycle;
- keeps a 4-deep stack of call offsets so each RTN undoes the matching CALL.

It sits between instruction decode and the register file and owns the architectural FP.

## Interface
Parameters:
- STACK_DEPTH, 4: number of stored CALL offsets. Must be a power of two.
- FP_MAX, 8: highest legal FP. FP+7 must not exceed 15.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Call_Req  in  1  CALL request, sampled only in IDLE.
- Rtn_Req  in  1  RTN request, sampled only in IDLE. Call_Req wins if both are high.
- Offset  in  3  CALL window offset I (0..7). Ignored for RTN.
- Busy  out  1  high in every non-IDLE state. Requests are ignored while Busy is high.
- Done  out  1  one-cycle pulse when a move completes.
- Fault  out  1  one-cycle pulse when a request is rejected.
- FP  out  4  current frame pointer, to the register file as the window base.
- New_FP  out  4  target frame pointer. Valid while FP_move is high, otherwise equals FP.
- FP_move  out  1  register-file window-move strobe, high for exactly one cycle per accepted request.
- FP_push_up  out  1  1 = CALL (window moves up), 0 = RTN. Valid with FP_move, otherwise 0.
- Move_Off  out  3  offset being applied, fed to the register file's Actual_Rs during a move. Otherwise 0.
- Depth  out  3  number of valid stack entries (0..STACK_DEPTH).

## Operation
- States: IDLE, MOVE, DONE, FAULT.
- Reset values: state IDLE, FP=0, Depth=0, stack entries 0. All outputs 0, with New_FP=0.
- In IDLE with Call_Req=1:
  - Legal when FP+Offset ≤ FP_MAX and Depth < STACK_DEPTH. The sum is computed 5 bits wide.
  - Legal: latch target = FP+Offset, push Offset, go to MOVE with push_up=1.
  - Illegal: go to FAULT. Stack and FP are unchanged.
- In IDLE with Rtn_Req=1 (and Call_Req=0):
  - Legal when Depth > 0: pop the top offset K, latch target = FP−K, go to MOVE with push_up=0.
  - Illegal (Depth = 0): go to FAULT.
- MOVE:
  - Drive FP_move=1, New_FP=target, Move_Off=applied offset, FP_push_up per direction.
  - At the end of the cycle, FP ← target. Go to DONE.
- DONE: Done=1 for one cycle, then go to IDLE.
- FAULT: Fault=1 for one cycle, then go to IDLE.
- CALL with Offset=0 is legal: FP is unchanged, the stack entry 0 is pushed, and FP_move still pulses.
- Push and pop take effect on the accept edge, so Depth updates one cycle after the request.
- Requests held high across Busy are re-sampled on return to IDLE. The decoder must drop a request after Done or Fault.
- Reset asserted in any state returns to the reset values on that edge. A move in flight is abandoned and FP_move is not asserted afterward.

## Timing
- Request sampled in IDLE at cycle T.
- T+1: MOVE or FAULT. Busy=1. FP_move or Fault asserted.
- T+2, accepted request: DONE, Done=1, FP shows the new value.
- T+2, faulted request: IDLE.
- Throughput:
  - one move per 3 cycles;
  - back-to-back request accepted at T+3;
  - a fault costs 2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from the request inputs to the outputs.

## Configuration
- Macro FP_STACK_CHECK_EN.
- Defined: overflow and underflow checks as described under Operation, with Fault generated.
- Undefined:
  - No request ever faults and Fault is tied to 0.
  - FP arithmetic wraps modulo 16.
  - A push when full overwrites the oldest entry (circular stack) and Depth saturates at STACK_DEPTH.
  - A pop when empty yields K=0. The move completes normally with New_FP=FP.

## Test plan
- Reset, then CALL Offset=3 -> T+1 FP_move=1, FP_push_up=1, New_FP=3, Move_Off=3 -> T+2 Done=1, FP=3, Depth=1.
- CALL 3, CALL 2, RTN, RTN -> FP sequence 3, 5, 3, 0. Move_Off on the RTNs is 2 then 3. Final Depth=0.
- FP=5, CALL Offset=4 (with FP_STACK_CHECK_EN) -> Fault pulse at T+1, FP stays 5, Depth unchanged, no FP_move.
- RTN at Depth=0:
  - with the macro -> Fault pulse;
  - without the macro -> FP_move=1, New_FP=FP, then Done.
- Call_Req and Rtn_Req both high at Depth=1 -> CALL performed (FP_push_up=1). Requests raised during MOVE/DONE are ignored until IDLE.
- Reset asserted during MOVE after CALL 2 from FP=0 -> next cycle FP=0, Depth=0, Busy=0, no Done pulse.
